// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU datapath defaults and register-file clear states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_DATA_W = 8;
    localparam int c_ADDR_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/regfile_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clear_ctrl
// Description : Sequential clear sweep controller with write/readback ready.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clear_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] c_LAST = '1;

    clr_state_t        r_state;
    clr_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready is registered so it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == IDLE);
        end
    end

    assign clr_busy = (r_state == CLEAR);
    assign wr_ready = r_ready;
    assign clr_addr = r_cnt;

endmodule : regfile_clear_ctrl
`default_nettype wire

// File: rtl/cpu_regfile_param.sv
`default_nettype none
// ============================================================================
// Module      : cpu_regfile_param
// Description : Parametrised 2R/1W register file with readback and clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_regfile_param
    import cpu_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              enable_write,
    input  logic              output_enable,
    input  logic              clr_req,
    output logic              wr_ready,
    output logic              clr_busy,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [c_DEPTH];
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_rd_locked;
    logic              w_wr_en;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .wr_ready (wr_ready),
        .clr_addr (w_clr_addr)
    );

    // Readback has priority: a combined request performs no write.
    assign w_wr_acc = wr_ready & enable_write & ~output_enable;
    assign w_rd_acc = wr_ready & output_enable;

    generate
        if (ZERO_REG != 0) begin : g_zero_reg
            assign w_rd_locked = (rd == '0);
        end else begin : g_no_zero_reg
            assign w_rd_locked = 1'b0;
        end
    endgenerate

    assign w_wr_en = w_wr_acc & ~w_rd_locked;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (clr_busy) begin
            r_regs[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_regs[rd] <= data_in;
        end
    end

    // Zero-register masking is applied last so it overrides the bypass path.
    always_comb begin
        reg_a = r_regs[rs];
        reg_b = r_regs[rt];
        if ((BYPASS != 0) && w_wr_acc && (rd == rs)) reg_a = data_in;
        if ((BYPASS != 0) && w_wr_acc && (rd == rt)) reg_b = data_in;
        if ((ZERO_REG != 0) && (rs == '0)) reg_a = '0;
        if ((ZERO_REG != 0) && (rt == '0)) reg_b = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_regs[rd];
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule : cpu_regfile_param
`default_nettype wire

// File: doc/cpu_regfile_param.md
Name: cpu_regfile_param

Overview:
- Parametrised CPU general-purpose register file with `DEPTH = 2**ADDR_W` entries, each `DATA_W` bits wide.
- Two combinational operand read ports (rs, rt), one synchronous write port, and one registered readback port (rd → data_out with valid strobe).
- Adds features the 8-bit/16-entry file lacks: optional hardwired-zero register, optional write-to-read bypass, and a software-requested sequential clear engine with a ready handshake.
- Sits between the decoder/control unit and the ALU.

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is an ordinary register.
- BYPASS, 1, 1 = rs/rt reads return wr_data when a write to the same address is accepted that cycle; 0 = return stored value.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- rs  in  ADDR_W  operand A read address.
- rt  in  ADDR_W  operand B read address.
- rd  in  ADDR_W  write / readback address.
- data_in  in  DATA_W  write data.
- enable_write  in  1  write request.
- output_enable  in  1  readback request.
- clr_req  in  1  start sequential clear (single-cycle pulse or level).
- wr_ready  out  1  1 = write/readback requests are accepted this cycle.
- clr_busy  out  1  clear sweep in progress.
- reg_a  out  DATA_W  registers[rs], combinational.
- reg_b  out  DATA_W  registers[rt], combinational.
- data_out  out  DATA_W  registered readback data.
- data_valid  out  1  one-cycle strobe qualifying data_out.

Behaviour:
- Reset (rst=0, async):
  - All entries = 0; FSM = IDLE; clear counter = 0.
  - data_out = 0, data_valid = 0, clr_busy = 0, wr_ready = 0 while rst=0.
  - Reset asserted mid-clear aborts the sweep. After rst deasserts, wr_ready = 1 on the first clock edge.
- FSM states: IDLE, CLEAR.
  - IDLE → CLEAR when clr_req=1 at a rising edge. The counter loads 0.
  - In CLEAR, each edge writes registers[cnt] = 0 and increments cnt.
  - At cnt == DEPTH-1 the last entry is cleared and the FSM returns to IDLE.
  - The sweep takes exactly DEPTH cycles. clr_busy = 1 for exactly those DEPTH cycles.
  - clr_req during CLEAR is ignored; it does not restart the sweep.
  - The counter wraps naturally at ADDR_W bits.
- wr_ready = 1 in IDLE only. In CLEAR, enable_write and output_enable are dropped (not queued); the requester must hold them until wr_ready=1.
- Write: accepted when wr_ready & enable_write & ~output_enable. registers[rd] = data_in at the edge. If ZERO_REG=1 and rd==0, the write is discarded.
- Readback: accepted when wr_ready & output_enable.
  - The next edge loads data_out = registers[rd] (value before any write that cycle) and sets data_valid = 1 for one cycle.
  - Otherwise data_valid = 0 and data_out holds its value.
  - enable_write & output_enable together: readback wins and no write occurs (exclusive, as in the 8-bit file).
- Reads:
  - reg_a/reg_b are combinational from the array.
  - ZERO_REG=1 and address 0 → 0, regardless of bypass.
  - BYPASS=1 and an accepted write with rd==rs → reg_a = data_in. Same rule for rt/reg_b.
  - During CLEAR, reads return the array contents, partially cleared. No bypass of clear zeros.
- clr_req in the same cycle as enable_write in IDLE: the write is accepted that edge (wr_ready=1), then the sweep clears it.
- No arithmetic beyond the counter. All data paths are DATA_W with no truncation.

Decomposition:
- Shared package `cpu_pkg`: the state enum typedef (IDLE, CLEAR) and default DATA_W/ADDR_W localparams shared with the ALU and decoder.
- Sub-module `regfile_clear_ctrl` owns the FSM, counter, clr_busy and wr_ready. The array, bypass and readback logic stay in the top.

Test Plan:
- Reset then read: rst=0 for 2 cycles → reg_a = reg_b = data_out = 0, data_valid = 0; wr_ready = 1 on the first edge after release.
- Write/readback: write rd=5, data_in=0xA7; next cycle rs=5 → reg_a = 0xA7; output_enable with rd=5 → next cycle data_out = 0xA7, data_valid = 1 for exactly 1 cycle.
- Bypass and zero register:
  - BYPASS=1: write rd=3, data_in=0x3C with rs=3 in the same cycle → reg_a = 0x3C combinationally.
  - ZERO_REG=1: write rd=0, data_in=0xFF → reg_a at rs=0 stays 0.
- Clear sweep: fill all 16 entries with 0x11..0x20, pulse clr_req.
  - clr_busy = 1 for exactly 16 cycles; wr_ready = 0 throughout; a write of 0x55 to rd=2 during the sweep has no effect.
  - Afterwards all entries read 0.
- Simultaneous requests and reset mid-clear:
  - enable_write and output_enable at rd=7 (old value 0x09, data_in=0x77) → data_out = 0x09 and entry stays 0x09.
  - Assert rst at sweep cycle 6 → clr_busy drops immediately and all entries read 0.
- Width scaling: DATA_W=16, ADDR_W=5 → write 0xBEEF to rd=31 and read it back; clear sweep takes exactly 32 cycles.
